// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded RV32I field bundles (R/I/S/B/U/J) into
// 32-bit machine words and writes them sequentially into instruction memory.
// Optional feature macro: ENC_RANGE_CHECK_EN -- when defined, out-of-range
// immediates make a bundle illegal; otherwise immediates are bit-sliced.
module rv_instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic signed [31:0]  in_imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                full,
  output logic                err,
  output logic [ADDR_W:0]     count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [ADDR_W-1:0] wp;
  logic [31:0]       word;
  logic              legal;
  logic              range_ok;
  logic              accept;

  // Bit placement of each RV32I format; fields a format does not use are ignored.
  function automatic logic [31:0] encode(
    input logic [2:0]         fmt,
    input logic [6:0]         op,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   w = {imm[31:12], rd, op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must be representable in the format's field without loss.
  function automatic logic imm_fits(
    input logic [2:0]         fmt,
    input logic signed [31:0] imm
  );
    logic ok;
    case (fmt)
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      FMT_B:        ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      FMT_J:        ok = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      FMT_U:        ok = (imm[11:0] == 12'h000);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  assign in_ready = !full && !start;
  assign accept   = in_valid && in_ready;

  // Encode the offered bundle and decide whether it may be written.
  always_comb begin
    word = encode(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
`ifdef ENC_RANGE_CHECK_EN
    range_ok = imm_fits(in_fmt, in_imm);
`else
    range_ok = 1'b1;
`endif
    legal = (in_fmt <= FMT_J) && range_ok;
  end

  // Write pointer, status flags and the registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wp        <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        wp    <= base_addr;
        full  <= 1'b0;
        err   <= 1'b0;
        count <= '0;
      end else if (accept) begin
        if (legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= wp;
          mem_wdata <= word;
          count     <= count + (ADDR_W+1)'(1);
          // The pointer parks on the last word instead of wrapping.
          if (wp == LAST_ADDR) full <= 1'b1;
          else                 wp   <= wp + ADDR_W'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: known-encoding table, hand-written
// corner sequences (range/illegal, full, reset, start collisions) and random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_rv_instr_encoder;

  localparam int AW   = 10;
  localparam int LAST = (1 << AW) - 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic              full;
  logic              err;
  logic [AW:0]       count;

  rv_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .full(full), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[6];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int       m_wp, m_count;
  bit       m_full, m_err, m_we;
  int       m_addr;
  bit [31:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Instruction word assembled from the ISA field layout with shifts and masks.
  function automatic bit [31:0] ref_word();
    bit [31:0] u;
    bit [31:0] base;
    u = in_imm;
    case (in_fmt)
      3'd0: return (32'(in_funct7) << 25) | (32'(in_rs2) << 20) | (32'(in_rs1) << 15)
                 | (32'(in_funct3) << 12) | (32'(in_rd) << 7) | 32'(in_opcode);
      3'd1: return ((u & 32'hFFF) << 20) | (32'(in_rs1) << 15) | (32'(in_funct3) << 12)
                 | (32'(in_rd) << 7) | 32'(in_opcode);
      3'd2: return (((u >> 5) & 32'h7F) << 25) | (32'(in_rs2) << 20) | (32'(in_rs1) << 15)
                 | (32'(in_funct3) << 12) | ((u & 32'h1F) << 7) | 32'(in_opcode);
      3'd3: begin
        base = (32'(in_rs2) << 20) | (32'(in_rs1) << 15) | (32'(in_funct3) << 12) | 32'(in_opcode);
        return base | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                    | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
      end
      3'd4: return (u & 32'hFFFFF000) | (32'(in_rd) << 7) | 32'(in_opcode);
      3'd5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                 | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                 | (32'(in_rd) << 7) | 32'(in_opcode);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal();
    int v;
    bit ok;
    v  = int'(in_imm);
    ok = (in_fmt <= 3'd5);
`ifdef ENC_RANGE_CHECK_EN
    case (in_fmt)
      3'd1, 3'd2: ok = (v >= -2048) && (v <= 2047);
      3'd3:       ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd5:       ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      3'd4:       ok = (v % 4096 == 0);
      default:    ;
    endcase
`else
    if (v == 12345678) ok = ok; // immediate only matters with range checking
`endif
    return ok;
  endfunction

  // One clock: check in_ready, advance the model, then compare outputs.
  task automatic step();
    bit exp_ready, acc, lg;
    bit [31:0] w;
    #1;
    exp_ready = !m_full && !start;
    check("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    lg  = ref_legal();
    w   = ref_word();
    @(posedge clk);
    #1;
    if (rst) begin
      m_wp = 0; m_count = 0; m_full = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (start) begin
        m_wp = int'(base_addr); m_full = 0; m_err = 0; m_count = 0;
      end else if (acc) begin
        if (lg) begin
          m_we = 1; m_addr = m_wp; m_data = w; m_count++;
          if (m_wp == LAST) m_full = 1;
          else m_wp++;
        end else begin
          m_err = 1;
        end
      end
    end
    check("mem_we", mem_we, m_we);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_data);
    check("full", full, m_full);
    check("err", err, m_err);
    check("count", count, m_count);
  endtask

  task automatic load(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask

  vec_t addi;

  initial begin
    //            fmt   opcode    f3    f7    rd  rs1 rs2 imm            word
    tbl[0] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093};
    tbl[1] = '{3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3};
    tbl[2] = '{3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423};
    tbl[3] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4,       32'hFE000EE3};
    tbl[4] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF};
    tbl[5] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7};
    addi = tbl[0];

    rst = 1; start = 0; base_addr = '0; in_valid = 0;
    load(addi);
    @(posedge clk);
    step();                      // reset state
    rst = 0;
    step();
    check("ready_after_reset", in_ready, 1'b1);

    // start at 0x010, then back-to-back table bundles
    start = 1; base_addr = 10'h010; step(); start = 0;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      load(tbl[i]);
      step();
      check($sformatf("tbl%0d_word", i), mem_wdata, tbl[i].word);
      check($sformatf("tbl%0d_addr", i), mem_addr, 32'h10 + i);
      check($sformatf("tbl%0d_count", i), count, i + 1);
    end
    in_valid = 0; step();

    // out-of-range immediates
    in_valid = 1; load(addi); in_imm = 32'd2048; step();
`ifdef ENC_RANGE_CHECK_EN
    check("imm2048_we", mem_we, 1'b0);
    check("imm2048_err", err, 1'b1);
`else
    check("imm2048_word", mem_wdata, 32'h80000093);
`endif
    load(tbl[3]); in_imm = 32'd3; step();
    load(addi); step();
`ifdef ENC_RANGE_CHECK_EN
    check("after_range_addr", mem_addr, 32'h16);
`else
    check("after_range_addr", mem_addr, 32'h18);
`endif
    in_valid = 0; step();

    // illegal format, then start clears err
    in_valid = 1; load(addi); in_fmt = 3'd7; step();
    check("fmt7_err", err, 1'b1);
    check("fmt7_we", mem_we, 1'b0);
    in_valid = 0; start = 1; base_addr = 10'h020; step(); start = 0;
    check("start_clears_err", err, 1'b0);

    // fill to the last address
    start = 1; base_addr = 10'(LAST - 3); step(); start = 0;
    in_valid = 1; load(addi);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("fill%0d_addr", k), mem_addr, LAST - 3 + k);
    end
    check("full_set", full, 1'b1);
    check("full_count", count, 4);
    step();
    check("held_we", mem_we, 1'b0);
    check("held_ready", in_ready, 1'b0);
    start = 1; base_addr = 10'd5; step(); start = 0;
    check("start_blocks_we", mem_we, 1'b0);
    step();
    check("released_addr", mem_addr, 5);
    check("released_we", mem_we, 1'b1);

    // reset in the cycle after an accept
    step();
    in_valid = 0; rst = 1; step(); rst = 0;
    check("rst_we", mem_we, 1'b0);
    check("rst_count", count, 0);

    // start together with in_valid
    in_valid = 1; start = 1; base_addr = 10'd100; step(); start = 0;
    check("start_valid_we", mem_we, 1'b0);
    step();
    check("start_valid_addr", mem_addr, 100);
    in_valid = 0; step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 29) == 0);
      base_addr = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(LAST - 6, LAST))
                                              : 10'($urandom_range(0, LAST));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fmt    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      in_opcode = 7'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 8191) - 4096);
      step();
    end
    rst = 0; start = 0; in_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
